// File: rtl/hm_pkg.sv
// -----------------------------------------------------------------------------
// hm_pkg
// Shared types and default constants for the heartbeat interval meter.
//   beat_state_t       : measurement FSM states
//   REFRACT_TICKS_DEF  : default refractory window in ticks (250 ms at 1 kHz)
//   TIMEOUT_TICKS_DEF  : default loss-of-pulse timeout in ticks (3 s at 1 kHz)
// -----------------------------------------------------------------------------
package hm_pkg;

   typedef enum logic {
      IDLE    = 1'b0,
      MEASURE = 1'b1
   } beat_state_t;

   localparam int REFRACT_TICKS_DEF = 250;
   localparam int TIMEOUT_TICKS_DEF = 3000;

endpackage : hm_pkg

// File: rtl/beat_interval_meter_if.sv
// -----------------------------------------------------------------------------
// beat_interval_meter_if
// Signal bundle between the pulse front end and the interval meter.
//   tick      : one-cycle sample-rate enable
//   beat_in   : raw comparator output, asynchronous to clk
//   interval  : ticks between the last two accepted beats (W bits)
//   load      : one-cycle strobe, interval is new
//   beat      : one-cycle strobe on every accepted beat
//   no_pulse  : level, no valid beat train present
// master drives tick/beat_in and observes the results; slave is the meter.
// -----------------------------------------------------------------------------
interface beat_interval_meter_if #(
   parameter int W = 12
);

   logic         tick;
   logic         beat_in;
   logic [W-1:0] interval;
   logic         load;
   logic         beat;
   logic         no_pulse;

   modport master (
      output tick,
      output beat_in,
      input  interval,
      input  load,
      input  beat,
      input  no_pulse
   );

   modport slave (
      input  tick,
      input  beat_in,
      output interval,
      output load,
      output beat,
      output no_pulse
   );

endinterface : beat_interval_meter_if

// File: rtl/sync_edge.sv
// -----------------------------------------------------------------------------
// sync_edge
// Two-flop synchronizer for an asynchronous level plus a rising-edge detector
// on the synchronized level. Suitable for any slow async input (beat
// comparator, push buttons).
//   clk       : system clock
//   rst       : synchronous reset, active-high
//   async_in  : asynchronous input level
//   sync_out  : synchronized level (second flop)
//   rise      : high for one cycle when sync_out goes 0 -> 1
// -----------------------------------------------------------------------------
module sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic async_in,
   output logic sync_out,
   output logic rise
);

   logic s1_q;
   logic s2_q;
   logic s3_q;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value of its neighbour, forming a true shift chain.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
         s3_q <= 1'b0;
      end else begin
         s1_q <= async_in;
         s2_q <= s1_q;
         s3_q <= s2_q;
      end
   end

   assign sync_out = s2_q;
   // s3 is the previous synchronized level; a rise needs it low, so two
   // rises are always at least two cycles apart.
   assign rise     = s2_q & ~s3_q;

endmodule : sync_edge

// File: rtl/beat_interval_meter.sv
// -----------------------------------------------------------------------------
// beat_interval_meter
// Measures the number of sample ticks between successive accepted heartbeats.
// The raw beat is synchronized and edge-detected; edges arriving within the
// refractory window after an accepted beat are ignored; if no beat is accepted
// for TIMEOUT_TICKS ticks the meter declares loss of pulse and re-arms.
//   clk   : system clock
//   rst   : synchronous reset, active-high
//   bus   : slave modport -- tick, beat_in in; interval, load, beat,
//           no_pulse out. interval/load feed the interval-holding register
//           (data/enable).
// Parameters:
//   W              width of the tick counter and interval; holds TIMEOUT_TICKS
//   REFRACT_TICKS  minimum ticks after an accepted beat before another edge
//   TIMEOUT_TICKS  ticks without an accepted beat before no_pulse
// -----------------------------------------------------------------------------
module beat_interval_meter
   import hm_pkg::*;
#(
   parameter int W             = 12,
   parameter int REFRACT_TICKS = REFRACT_TICKS_DEF,
   parameter int TIMEOUT_TICKS = TIMEOUT_TICKS_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   beat_interval_meter_if.slave  bus
);

   // Thresholds widened by one bit so count + 1 is compared without wrap.
   localparam logic [W:0] REFRACT_C = (W+1)'(REFRACT_TICKS);
   localparam logic [W:0] TIMEOUT_C = (W+1)'(TIMEOUT_TICKS);

   beat_state_t  state_q, state_d;
   logic [W-1:0] count_q, count_d;
   logic [W-1:0] interval_q, interval_d;
   logic         load_q, load_d;
   logic         beat_q, beat_d;
   logic         no_pulse_q, no_pulse_d;

   logic         edge_det;
   logic         beat_lvl_unused;
   logic [W:0]   count_inc;
   logic         past_refract;

   sync_edge u_sync_edge (
      .clk      (clk),
      .rst      (rst),
      .async_in (bus.beat_in),
      .sync_out (beat_lvl_unused),
      .rise     (edge_det)
   );

   assign count_inc    = {1'b0, count_q} + (W+1)'(1);
   assign past_refract = ({1'b0, count_q} >= REFRACT_C);

   // NOTE: every signal written here gets a default first, so no path leaves
   // a value unassigned and no latch is inferred.
   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      interval_d = interval_q;
      load_d     = 1'b0;
      beat_d     = 1'b0;
      no_pulse_d = no_pulse_q;

      unique case (state_q)
         IDLE: begin
            count_d = '0;
            // First beat of a train: there is no interval to report yet.
            if (edge_det) begin
               beat_d     = 1'b1;
               no_pulse_d = 1'b0;
               state_d    = MEASURE;
            end
         end

         MEASURE: begin
            if (edge_det && past_refract) begin
               // The tick coinciding with the accepted edge belongs to this
               // interval. Accepted edges take priority over a timeout.
               interval_d = count_q + W'(bus.tick);
               load_d     = 1'b1;
               beat_d     = 1'b1;
               count_d    = '0;
            end else if (bus.tick) begin
               // Edges inside the refractory window fall through here and
               // leave the measurement running untouched.
               if (count_inc == TIMEOUT_C) begin
                  no_pulse_d = 1'b1;
                  count_d    = '0;
                  state_d    = IDLE;
               end else begin
                  count_d = count_inc[W-1:0];
               end
            end
         end

         default: begin
            state_d = IDLE;
            count_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         count_q    <= '0;
         interval_q <= '0;
         load_q     <= 1'b0;
         beat_q     <= 1'b0;
         no_pulse_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         interval_q <= interval_d;
         load_q     <= load_d;
         beat_q     <= beat_d;
         no_pulse_q <= no_pulse_d;
      end
   end

   assign bus.interval = interval_q;
   assign bus.load     = load_q;
   assign bus.beat     = beat_q;
   assign bus.no_pulse = no_pulse_q;

endmodule : beat_interval_meter

// File: doc/beat_interval_meter.md
Name: beat_interval_meter

Overview:
- Measures the time between successive heartbeats from the pulse-sensor comparator output, in units of a sample-rate tick.
- Synchronizes and edge-detects the raw beat signal, rejects edges inside a refractory window, and flags loss of pulse on timeout.
- Sits directly upstream of the interval-holding register: `interval` drives its data input and `load` drives its enable. The rate/display logic reads that register.

Parameters:
- W, 12, width of the tick counter and of `interval`; must hold TIMEOUT_TICKS.
- REFRACT_TICKS, 250, minimum ticks after an accepted beat before another edge is accepted (250 ms at 1 kHz, about 240 bpm max).
- TIMEOUT_TICKS, 3000, ticks without an accepted beat before declaring no pulse (about 20 bpm min).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- tick  in  1  one-cycle sample-rate enable (e.g. 1 kHz strobe); may be tied high.
- beat_in  in  1  raw comparator output; asynchronous to clk.
- interval  out  W  ticks between the last two accepted beats; held between updates.
- load  out  1  one-cycle strobe, high in the cycle `interval` is new.
- beat  out  1  one-cycle strobe on every accepted beat, including the first.
- no_pulse  out  1  level; high when no valid beat train is present.

Behaviour:
- Reset: `interval`=0, `load`=0, `beat`=0, `no_pulse`=1, state=IDLE, count=0, sync/edge flops=0. Reset wins over every other event and suppresses any pending `load`.
- Synchronizer and edge detect:
  - beat_in passes through 2 flops (s1, s2), then a third flop s3.
  - edge = s2 & ~s3.
  - beat_in first sampled high at edge E0 makes `edge` valid in the cycle before E0+2; the FSM acts on it at E0+2.
- count:
  - W-bit; increments by 1 on each cycle with tick=1 while in MEASURE.
  - Never wraps; the timeout occurs first.
- State IDLE:
  - count held at 0.
  - Any edge is accepted: beat=1, count<=0, no_pulse<=0, go to MEASURE.
  - No `load` is issued (no interval exists yet).
- State MEASURE, edge with count >= REFRACT_TICKS (accepted):
  - interval <= count + tick; the tick coinciding with the edge is counted.
  - load=1 and beat=1 for exactly one cycle.
  - count <= 0.
- State MEASURE, edge with count < REFRACT_TICKS: ignored entirely, with no output change.
- State MEASURE, timeout:
  - Condition: tick=1, no accepted edge, and count+1 == TIMEOUT_TICKS.
  - Actions: no_pulse<=1, count<=0, go to IDLE. `interval` is unchanged and no `load` is issued.
- Edge and timeout in the same cycle: the accepted edge wins.
- Latency: beat_in rising at sample edge E0 gives `interval`, `load` and `beat` registered at edge E0+2, so they are visible in the cycle after E0+2.
- `load` and `beat` are never high for two consecutive cycles: an edge needs s3 low, so accepted edges are at least 2 cycles apart.
- beat_in held high through reset: one edge is detected after reset release and is treated as a first beat (IDLE path, no `load`).

Decomposition:
- hm_pkg holds:
  - typedef enum logic {IDLE, MEASURE} beat_state_t;
  - default constants REFRACT_TICKS_DEF and TIMEOUT_TICKS_DEF.
- One sub-module, sync_edge: 2-flop synchronizer plus rising-edge detect. Ports: clk, rst, async_in, sync_out, rise. Reusable for button inputs elsewhere.
- FSM, counter and output registers live in beat_interval_meter.

Test Plan:
All scenarios use W=8, REFRACT_TICKS=4, TIMEOUT_TICKS=20, and tick tied high unless stated.
1. Reset: hold rst 3 cycles with beat_in=0 -> interval=0, load=0, beat=0, no_pulse=1.
2. Two beats: beat_in rising, then rising again 10 cycles later:
   - first edge -> beat=1, load=0, no_pulse=0 two edges after the sample;
   - second edge -> interval=10 with a single-cycle load=1.
3. Refractory: beats at t=0 and t=10 with a glitch at t=3 -> glitch gives no beat and no load; second beat still reports interval=10.
4. Timeout: one beat, then beat_in low for 25 cycles -> no_pulse=1 exactly 20 ticks after the accepted beat, interval unchanged, no load. A later beat -> beat=1, load=0, no_pulse=0.
5. Sparse tick: tick every 4th cycle, beats 40 cycles apart -> interval=10.
6. Reset mid-measure: reset 5 cycles after a beat -> outputs return to reset values and no load appears. The next two beats 7 cycles apart -> interval=7.
